// File: rtl/normalize_shift_module_pkg.sv
// Shared FPU definitions for the normalize/shift stage: FSM state encoding,
// default field widths and the saturated (all-ones) exponent value.
package normalize_shift_module_pkg;

  localparam int unsigned MANT_W_DEF = 23;
  localparam int unsigned EXP_W_DEF  = 8;

  // Exponent field value that marks overflow/infinity at the default width.
  localparam logic [EXP_W_DEF-1:0] EXP_MAX = '1;

  typedef logic [1:0] norm_state_t;

  localparam norm_state_t IDLE  = 2'd0;
  localparam norm_state_t EVAL  = 2'd1;
  localparam norm_state_t SHIFT = 2'd2;
  localparam norm_state_t DONE  = 2'd3;

endpackage

// File: rtl/lzc24.sv
// 24-bit leading-zero counter for the single-cycle normalize shift.
// Only compiled when NORM_FAST_LZC_EN is defined; empty otherwise.
`ifdef NORM_FAST_LZC_EN
module lzc24 (
  input  logic [23:0] data_i,
  output logic [4:0]  count_o
);

  // Scan upward so the highest set bit makes the final assignment; all-zero gives 24.
  always_comb begin
    count_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (data_i[i]) count_o = 5'(23 - i);
    end
  end

endmodule
`endif

// File: rtl/normalize_shift_module.sv
// Post-add normalization: takes the raw adder sum plus the common exponent,
// fixes a carry-out with a right shift, or left-normalizes until the hidden
// bit is set (stopping at the denormal boundary), and flags zero, overflow and
// underflow. Handshaked on both sides; one operand in flight at a time.
// Build option: define NORM_FAST_LZC_EN to do the whole left shift in one cycle
// via lzc24 (requires MANT_W = 23); results are identical either way.
module normalize_shift_module
  import normalize_shift_module_pkg::*;
#(
  parameter int unsigned MANT_W = MANT_W_DEF,
  parameter int unsigned EXP_W  = EXP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              Sign_in,
  input  logic [MANT_W+1:0] Mantissa_sum,
  input  logic [EXP_W-1:0]  EXP_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              Sign_out,
  output logic [MANT_W-1:0] Mantissa_norm,
  output logic [EXP_W-1:0]  EXP_norm,
  output logic              overflow,
  output logic              underflow,
  output logic              zero
);

  // Exponent math carries one spare bit so increments/decrements never wrap.
  localparam logic [EXP_W:0] ExpOne = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] ExpMax = {1'b0, {EXP_W{1'b1}}};

  norm_state_t       state_q, state_d;
  logic [MANT_W+1:0] work_q, work_d;
  logic [EXP_W:0]    exp_q, exp_d;
  logic              sign_q, sign_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  expn_q, expn_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              zero_q, zero_d;

  logic [EXP_W:0]    exp_inc;
  logic [MANT_W:0]   sh_work;
  logic [EXP_W:0]    sh_exp;

`ifdef NORM_FAST_LZC_EN
  logic [4:0]     lzc;
  logic [EXP_W:0] lzc_ext;
  logic [EXP_W:0] exp_room;
  logic [EXP_W:0] shamt;

  lzc24 u_lzc (
    .data_i  (work_q[MANT_W:0]),
    .count_o (lzc)
  );

  // Whole normalize in one step, clamped so the exponent never drops below 1.
  always_comb begin
    lzc_ext  = (EXP_W+1)'(lzc);
    exp_room = exp_q - ExpOne;
    shamt    = (lzc_ext < exp_room) ? lzc_ext : exp_room;
    sh_work  = work_q[MANT_W:0] << shamt;
    sh_exp   = exp_q - shamt;
  end
`else
  // One bit per cycle; at exponent 1 there is no room left, so hold.
  always_comb begin
    if (exp_q > ExpOne) begin
      sh_work = work_q[MANT_W:0] << 1;
      sh_exp  = exp_q - ExpOne;
    end else begin
      sh_work = work_q[MANT_W:0];
      sh_exp  = exp_q;
    end
  end
`endif

  // FSM next-state and result datapath.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    mant_d  = mant_q;
    expn_d  = expn_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    zero_d  = zero_q;
    exp_inc = exp_q + ExpOne;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = Mantissa_sum;
          exp_d   = {1'b0, EXP_in};
          sign_d  = Sign_in;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (work_q == '0) begin
          zero_d  = 1'b1;
          expn_d  = '0;
          mant_d  = '0;
          state_d = DONE;
        end else if (work_q[MANT_W+1]) begin
          // Carry out: renormalize right; saturate instead of wrapping.
          if (exp_inc >= ExpMax) begin
            ovf_d  = 1'b1;
            expn_d = '1;
            mant_d = '0;
          end else begin
            expn_d = exp_inc[EXP_W-1:0];
            mant_d = work_q[MANT_W:1];
          end
          state_d = DONE;
        end else if (work_q[MANT_W] || exp_q == '0) begin
          expn_d  = exp_q[EXP_W-1:0];
          mant_d  = work_q[MANT_W-1:0];
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = {1'b0, sh_work};
        exp_d  = sh_exp;
        if (sh_work[MANT_W]) begin
          expn_d  = sh_exp[EXP_W-1:0];
          mant_d  = sh_work[MANT_W-1:0];
          state_d = DONE;
        end else if (sh_exp <= ExpOne) begin
          // Ran out of exponent before the hidden bit appeared: denormal.
          unf_d   = 1'b1;
          expn_d  = '0;
          mant_d  = sh_work[MANT_W-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      mant_q  <= '0;
      expn_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      mant_q  <= mant_d;
      expn_q  <= expn_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign Sign_out      = sign_q;
  assign Mantissa_norm = mant_q;
  assign EXP_norm      = expn_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;
  assign zero          = zero_q;

endmodule

// File: doc/normalize_shift_module.md
NORMALIZE_SHIFT_MODULE -- requirements
Module: normalize_shift_module

Interface
REQ-001 Parameters SHALL be:
- MANT_W, default 23, stored fraction width.
- EXP_W, default 8, biased exponent width.

REQ-002 Ports SHALL be (clock and reset first):
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input operand valid.
- in_ready  out  1  module can accept an operand.
- Sign_in  in  1  result sign from adder.
- Mantissa_sum  in  MANT_W+2  raw adder sum: [24] carry, [23] hidden bit, [22:0] fraction.
- EXP_in  in  EXP_W  common exponent from the alignment stage.
- out_valid  out  1  normalized result valid.
- out_ready  in  1  consumer accepts the result.
- Sign_out  out  1  registered Sign_in.
- Mantissa_norm  out  MANT_W  normalized fraction, hidden bit dropped.
- EXP_norm  out  EXP_W  normalized exponent.
- overflow  out  1  exponent saturated to all-ones.
- underflow  out  1  result denormal.
- zero  out  1  result is exact zero.

Function
REQ-003 FSM states SHALL be IDLE, EVAL, SHIFT, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-004 IDLE SHALL go to EVAL when in_valid is high, registering Mantissa_sum into a 25-bit work register; EXP_in and Sign_in SHALL be registered on the same edge.
REQ-005 EVAL, work==0: zero=1, EXP_norm=0, Mantissa_norm=0 -> DONE.
REQ-006 EVAL, work[24]=1: work>>1, exp+1 -> DONE; if exp+1 == all-ones, overflow=1 and Mantissa_norm=0.
REQ-007 EVAL, work[24:23]=01, or EXP_in==0: pass through unchanged -> DONE.
REQ-008 EVAL, otherwise (work[24:23]=00, EXP_in>0) -> SHIFT.
REQ-009 Each SHIFT cycle: work<<1, exp-1.
REQ-010 SHIFT exit: -> DONE when shifted work[23]=1; or when exp reaches 1 with work[23]=0, in which case EXP_norm=0, underflow=1, Mantissa_norm=work[22:0].
REQ-011 Latency, accept cycle c: DONE at c+2 with no shift; c+2+n with n single-bit shifts.
REQ-012 DONE SHALL hold all outputs stable until out_ready=1, then return to IDLE; no new operand is accepted in that same cycle.
REQ-013 Flags SHALL be mutually exclusive and cleared on every new accept.
REQ-014 Exponent arithmetic SHALL be EXP_W+1 bits wide internally; no wrap-around SHALL reach EXP_norm.

Reset
REQ-015 When rst_n=0 at a clock edge: state=IDLE; out_valid, overflow, underflow, zero, Sign_out, Mantissa_norm, EXP_norm all 0; in_ready=1 after that edge.
REQ-016 Reset in any state, including mid-SHIFT or DONE under backpressure, SHALL discard the in-flight operand.

Configuration
REQ-017 Macro NORM_FAST_LZC_EN:
- Defined: SHIFT SHALL last exactly one cycle, shifting by min(leading-zero count of work[23:0], exp-1); latency is c+3 whenever a shift is needed.
- Undefined: one bit per cycle per REQ-009/REQ-010.
- Results SHALL be bit-identical in both builds.

Structure
REQ-018 Shared FPU package SHALL hold the FSM state typedef, MANT_W/EXP_W defaults and the EXP_MAX (all-ones) constant.
REQ-019 With NORM_FAST_LZC_EN defined, leading-zero counting SHALL be sub-module lzc24 (24-bit in, 5-bit count out, combinational); otherwise no sub-module.

Verification
REQ-020 Carry: Mantissa_sum=25'h1000000, EXP_in=8'h7F -> EXP_norm=8'h80, Mantissa_norm=0, out_valid at c+2.
REQ-021 Two-bit left shift: 25'h0200000, EXP_in=8'h80 -> EXP_norm=8'h7E, Mantissa_norm=0, out_valid at c+4 (c+3 with LZC).
REQ-022 Overflow: 25'h1800000, EXP_in=8'hFE -> EXP_norm=8'hFF, Mantissa_norm=0, overflow=1.
REQ-023 Underflow: 25'h0000001, EXP_in=8'h03 -> EXP_norm=0, Mantissa_norm=23'h000004, underflow=1.
REQ-024 Zero: 25'h0, EXP_in=8'h55 -> zero=1, EXP_norm=0, out_valid at c+2.
REQ-025 Backpressure and reset:
- out_ready=0 for 5 cycles in DONE -> outputs unchanged.
- rst_n=0 during SHIFT -> out_valid=0 and in_ready=1 after that edge.
